// File: rtl/dp_ram_pkg.sv
// Shared constants and helper functions for the dual-port RAM slice.
`timescale 1ns/1ps
package dp_ram_pkg;

  localparam int BYTE_W     = 8;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_LANES  = MAX_DATA_W / BYTE_W;

  function automatic int lane_count(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Per-lane merge: the winner's byte if it enables the lane, else the
  // loser's byte if it does, else the old byte is kept.
  function automatic logic [MAX_DATA_W-1:0] byte_merge(
    input logic [MAX_DATA_W-1:0] win_d,
    input logic [MAX_LANES-1:0]  win_be,
    input logic [MAX_DATA_W-1:0] lose_d,
    input logic [MAX_LANES-1:0]  lose_be,
    input logic [MAX_DATA_W-1:0] old_d
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_d;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (win_be[i])
        res[i*BYTE_W +: BYTE_W] = win_d[i*BYTE_W +: BYTE_W];
      else if (lose_be[i])
        res[i*BYTE_W +: BYTE_W] = lose_d[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dp_ram_arb_if.sv
// Bus bundle for both RAM ports plus the collision status outputs.
`timescale 1ns/1ps
interface dp_ram_arb_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                    cs_a, we_a, cs_b, we_b;
  logic [DATA_WIDTH/8-1:0] be_a, be_b;
  logic [ADDR_WIDTH-1:0]   addr_a, addr_b;
  logic [DATA_WIDTH-1:0]   din_a, din_b, dout_a, dout_b;
  logic                    rvalid_a, rvalid_b, collision;
  logic [CNT_WIDTH-1:0]    collision_cnt;

  modport master (
    output cs_a, we_a, be_a, addr_a, din_a,
    output cs_b, we_b, be_b, addr_b, din_b,
    input  dout_a, rvalid_a, dout_b, rvalid_b, collision, collision_cnt
  );

  modport slave (
    input  cs_a, we_a, be_a, addr_a, din_a,
    input  cs_b, we_b, be_b, addr_b, din_b,
    output dout_a, rvalid_a, dout_b, rvalid_b, collision, collision_cnt
  );
endinterface

// File: rtl/dp_ram_rd_stage.sv
// Read result register with an optional second pipeline stage and the
// matching one-cycle read-valid flag. dout holds when no read completes.
`timescale 1ns/1ps
module dp_ram_rd_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rvalid
);
  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_valid;

  // First stage: capture the word on the edge the read is issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= rd_data;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      // Second stage: delay the captured word and its valid by one cycle.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign dout   = s2_data;
      assign rvalid = s2_valid;
    end else begin : g_direct
      assign dout   = s1_data;
      assign rvalid = s1_valid;
    end
  endgenerate
endmodule

// File: rtl/dp_ram_arb.sv
// True dual-port RAM with byte-lane writes, per-lane same-address write
// arbitration, selectable cross-port read-during-write and a saturating
// collision counter.
`timescale 1ns/1ps
module dp_ram_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int PRIO_B     = 0,
  parameter int RDW_NEW    = 0,
  parameter int OUT_REG    = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        reset,
  dp_ram_arb_if.slave bus
);
  import dp_ram_pkg::*;

  localparam int          LANES   = lane_count(DATA_WIDTH);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF >> (32 - CNT_WIDTH);

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  in_range_a, in_range_b, wr_a, wr_b, rd_a, rd_b;
  logic                  same_addr, dual_write, conflict;
  logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, dual_word;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;
  logic [LANES-1:0]      be_prio, be_other;
  logic [DATA_WIDTH-1:0] din_prio, din_other;
  logic                  collision_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  // Decode both ports, arbitrate a same-address double write per lane and
  // pick the data each reader sees.
  always_comb begin
    in_range_a = 32'(bus.addr_a) < RAM_DEPTH;
    in_range_b = 32'(bus.addr_b) < RAM_DEPTH;
    wr_a       = bus.cs_a & bus.we_a & in_range_a;
    wr_b       = bus.cs_b & bus.we_b & in_range_b;
    rd_a       = bus.cs_a & ~bus.we_a;
    rd_b       = bus.cs_b & ~bus.we_b;
    same_addr  = bus.addr_a == bus.addr_b;
    dual_write = wr_a & wr_b & same_addr;
    conflict   = bus.cs_a & bus.cs_b & same_addr & (bus.we_a | bus.we_b);

    old_a = in_range_a ? mem[bus.addr_a] : '0;
    old_b = in_range_b ? mem[bus.addr_b] : '0;

    be_prio   = (PRIO_B != 0) ? bus.be_b  : bus.be_a;
    din_prio  = (PRIO_B != 0) ? bus.din_b : bus.din_a;
    be_other  = (PRIO_B != 0) ? bus.be_a  : bus.be_b;
    din_other = (PRIO_B != 0) ? bus.din_a : bus.din_b;

    dual_word = DATA_WIDTH'(byte_merge(MAX_DATA_W'(din_prio), MAX_LANES'(be_prio),
                                       MAX_DATA_W'(din_other), MAX_LANES'(be_other),
                                       MAX_DATA_W'(old_a)));

    new_a = dual_write ? dual_word
          : DATA_WIDTH'(byte_merge(MAX_DATA_W'(bus.din_a), MAX_LANES'(bus.be_a),
                                   '0, '0, MAX_DATA_W'(old_a)));
    new_b = dual_write ? dual_word
          : DATA_WIDTH'(byte_merge(MAX_DATA_W'(bus.din_b), MAX_LANES'(bus.be_b),
                                   '0, '0, MAX_DATA_W'(old_b)));

    rd_data_a = old_a;
    if (!in_range_a)
      rd_data_a = '0;
    else if ((RDW_NEW != 0) && wr_b && same_addr)
      rd_data_a = new_b;

    rd_data_b = old_b;
    if (!in_range_b)
      rd_data_b = '0;
    else if ((RDW_NEW != 0) && wr_a && same_addr)
      rd_data_b = new_a;
  end

  // Memory array; a double write stores the same merged word from both ports.
  always_ff @(posedge clk) begin
    if (wr_a) mem[bus.addr_a] <= new_a;
    if (wr_b) mem[bus.addr_b] <= new_b;
  end

  // Registered collision pulse and saturating collision count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      collision_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      collision_q <= conflict;
      if (conflict) cnt_q <= CNT_WIDTH'(sat_inc(32'(cnt_q), CNT_MAX));
    end
  end

  dp_ram_rd_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_rd_a (
    .clk(clk), .reset(reset), .rd_en(rd_a), .rd_data(rd_data_a),
    .dout(bus.dout_a), .rvalid(bus.rvalid_a)
  );

  dp_ram_rd_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_rd_b (
    .clk(clk), .reset(reset), .rd_en(rd_b), .rd_data(rd_data_b),
    .dout(bus.dout_b), .rvalid(bus.rvalid_b)
  );

  assign bus.collision     = collision_q;
  assign bus.collision_cnt = cnt_q;
endmodule

// File: tb/tb_dp_ram_arb.sv
// Bench for dp_ram_arb: two differently configured instances share one
// stimulus stream and are compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_dp_ram_arb;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 200;

  typedef struct {
    logic          cs;
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } port_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  port_t pa, pb;
  int total = 0;
  int bad   = 0;

  dp_ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(2))  bus0 ();
  dp_ram_arb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(16)) bus1 ();

  assign bus0.cs_a = pa.cs;   assign bus1.cs_a = pa.cs;
  assign bus0.we_a = pa.we;   assign bus1.we_a = pa.we;
  assign bus0.be_a = pa.be;   assign bus1.be_a = pa.be;
  assign bus0.addr_a = pa.addr; assign bus1.addr_a = pa.addr;
  assign bus0.din_a = pa.din; assign bus1.din_a = pa.din;
  assign bus0.cs_b = pb.cs;   assign bus1.cs_b = pb.cs;
  assign bus0.we_b = pb.we;   assign bus1.we_b = pb.we;
  assign bus0.be_b = pb.be;   assign bus1.be_b = pb.be;
  assign bus0.addr_b = pb.addr; assign bus1.addr_b = pb.addr;
  assign bus0.din_b = pb.din; assign bus1.din_b = pb.din;

  logic [DW-1:0] dout_q [2][2];
  logic          rvalid_q [2][2];
  logic          coll_q [2];
  logic [31:0]   cnt_q [2];

  assign dout_q[0][0] = bus0.dout_a;   assign dout_q[0][1] = bus0.dout_b;
  assign dout_q[1][0] = bus1.dout_a;   assign dout_q[1][1] = bus1.dout_b;
  assign rvalid_q[0][0] = bus0.rvalid_a; assign rvalid_q[0][1] = bus0.rvalid_b;
  assign rvalid_q[1][0] = bus1.rvalid_a; assign rvalid_q[1][1] = bus1.rvalid_b;
  assign coll_q[0] = bus0.collision;   assign coll_q[1] = bus1.collision;
  assign cnt_q[0] = 32'(bus0.collision_cnt);
  assign cnt_q[1] = 32'(bus1.collision_cnt);

  dp_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .PRIO_B(0),
               .RDW_NEW(0), .OUT_REG(1), .CNT_WIDTH(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  dp_ram_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH), .PRIO_B(1),
               .RDW_NEW(1), .OUT_REG(0), .CNT_WIDTH(16)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Model configuration per instance.
  int m_prio [2];
  int m_rdw  [2];
  int m_lat  [2];
  int m_max  [2];

  // Model state: memory image, and per port a history of completed reads.
  logic [DW-1:0] m_mem [2][256];
  logic [DW-1:0] m_last [2][2];
  bit            m_pend [2][2][3];
  logic [DW-1:0] m_pdat [2][2][3];
  bit            m_coll [2];
  int            m_cnt  [2];

  function automatic port_t idle();
    port_t p;
    p.cs = 1'b0; p.we = 1'b0; p.be = 2'b00; p.addr = '0; p.din = '0;
    return p;
  endfunction

  function automatic port_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] din,
                               input logic [1:0] be);
    port_t p;
    p.cs = 1'b1; p.we = 1'b1; p.be = be; p.addr = addr; p.din = din;
    return p;
  endfunction

  function automatic port_t rd(input logic [AW-1:0] addr);
    port_t p;
    p.cs = 1'b1; p.we = 1'b0; p.be = 2'b00; p.addr = addr; p.din = '0;
    return p;
  endfunction

  // Word stored at addr after this edge, lane by lane from the priority rule.
  function automatic logic [DW-1:0] final_word(input int k, input logic [AW-1:0] addr,
                                               input port_t a, input port_t b);
    logic [DW-1:0] w;
    bit ea, eb;
    w = m_mem[k][addr];
    for (int i = 0; i < 2; i++) begin
      ea = a.cs && a.we && (int'(a.addr) < DEPTH) && (a.addr == addr) && a.be[i];
      eb = b.cs && b.we && (int'(b.addr) < DEPTH) && (b.addr == addr) && b.be[i];
      if (m_prio[k] != 0) begin
        if (eb) w[8*i +: 8] = b.din[8*i +: 8];
        else if (ea) w[8*i +: 8] = a.din[8*i +: 8];
      end else begin
        if (ea) w[8*i +: 8] = a.din[8*i +: 8];
        else if (eb) w[8*i +: 8] = b.din[8*i +: 8];
      end
    end
    return w;
  endfunction

  function automatic logic [DW-1:0] read_value(input int k, input port_t me, input port_t other);
    if (int'(me.addr) >= DEPTH) return '0;
    if (m_rdw[k] != 0 && other.cs && other.we && other.addr == me.addr)
      return final_word(k, me.addr, me, other);
    return m_mem[k][me.addr];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_coll[k] = 1'b0;
      m_cnt[k]  = 0;
      for (int p = 0; p < 2; p++) begin
        m_last[k][p] = '0;
        for (int d = 0; d < 3; d++) begin
          m_pend[k][p][d] = 1'b0;
          m_pdat[k][p][d] = '0;
        end
      end
    end
  endtask

  // Advance the model across one clock edge. A read issued now completes
  // m_lat edges later; m_pend[..][0] is the read completing at this edge.
  task automatic model_edge(input port_t a, input port_t b);
    logic [DW-1:0] fa, fb, ra, rb;
    for (int k = 0; k < 2; k++) begin
      ra = read_value(k, a, b);
      rb = read_value(k, b, a);
      fa = final_word(k, a.addr, a, b);
      fb = final_word(k, b.addr, a, b);
      for (int p = 0; p < 2; p++) begin
        for (int d = 0; d < 2; d++) begin
          m_pend[k][p][d] = m_pend[k][p][d+1];
          m_pdat[k][p][d] = m_pdat[k][p][d+1];
        end
        m_pend[k][p][2] = 1'b0;
      end
      m_pend[k][0][m_lat[k]-1] = a.cs && !a.we;
      m_pdat[k][0][m_lat[k]-1] = ra;
      m_pend[k][1][m_lat[k]-1] = b.cs && !b.we;
      m_pdat[k][1][m_lat[k]-1] = rb;
      for (int p = 0; p < 2; p++)
        if (m_pend[k][p][0]) m_last[k][p] = m_pdat[k][p][0];
      if (a.cs && a.we && int'(a.addr) < DEPTH) m_mem[k][a.addr] = fa;
      if (b.cs && b.we && int'(b.addr) < DEPTH) m_mem[k][b.addr] = fb;
      m_coll[k] = a.cs && b.cs && (a.addr == b.addr) && (a.we || b.we);
      if (m_coll[k]) m_cnt[k] = (m_cnt[k] >= m_max[k]) ? m_max[k] : m_cnt[k] + 1;
    end
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s inst%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model for the edge just taken.
  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      check("dout_a",   k, 32'(dout_q[k][0]),   32'(m_last[k][0]));
      check("rvalid_a", k, 32'(rvalid_q[k][0]), 32'(m_pend[k][0][0]));
      check("dout_b",   k, 32'(dout_q[k][1]),   32'(m_last[k][1]));
      check("rvalid_b", k, 32'(rvalid_q[k][1]), 32'(m_pend[k][1][0]));
      check("collision", k, 32'(coll_q[k]), 32'(m_coll[k]));
      check("collision_cnt", k, cnt_q[k], 32'(m_cnt[k]));
    end
  endtask

  task automatic applyStimulus(input port_t a, input port_t b, input logic r);
    pa = a;
    pb = b;
    reset = r;
    if (r) model_reset();
    else model_edge(a, b);
  endtask

  task automatic step(input port_t a, input port_t b, input logic r);
    @(negedge clk);
    checkOutput();
    applyStimulus(a, b, r);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(idle(), idle(), 1'b0);
  endtask

  port_t ra, rb;

  initial begin
    m_prio = '{0, 1};
    m_rdw  = '{0, 1};
    m_lat  = '{2, 1};
    m_max  = '{3, 65535};
    model_reset();
    pa = rd(8'h10);
    pb = idle();
    reset = 1'b1;

    // Read requested while reset is held produces nothing.
    step(rd(8'h10), idle(), 1'b1);
    step(rd(8'h10), idle(), 1'b1);
    for (int k = 0; k < 2; k++) begin
      check("rst_dout_a", k, 32'(dout_q[k][0]), 32'h0);
      check("rst_rvalid_a", k, 32'(rvalid_q[k][0]), 32'h0);
      check("rst_cnt", k, cnt_q[k], 32'h0);
    end

    // Fill every in-range word so later reads are defined.
    for (int i = 0; i < DEPTH / 2; i++)
      step(wr(AW'(2*i), DW'($urandom), 2'b11), wr(AW'(2*i+1), DW'($urandom), 2'b11), 1'b0);

    // Read latency: instance 1 after one edge, instance 0 after two.
    step(rd(8'h10), idle(), 1'b0);
    step(idle(), idle(), 1'b0);
    check("lat1_rvalid", 1, 32'(rvalid_q[1][0]), 32'h1);
    check("lat1_rvalid", 0, 32'(rvalid_q[0][0]), 32'h0);
    step(idle(), idle(), 1'b0);
    check("lat2_rvalid", 0, 32'(rvalid_q[0][0]), 32'h1);
    check("lat2_rvalid", 1, 32'(rvalid_q[1][0]), 32'h0);

    // Parallel writes to different addresses.
    step(wr(8'h05, 16'h00AA, 2'b11), wr(8'h06, 16'h0055, 2'b11), 1'b0);
    step(idle(), idle(), 1'b0);
    for (int k = 0; k < 2; k++) check("par_coll", k, 32'(coll_q[k]), 32'h0);
    step(rd(8'h05), rd(8'h06), 1'b0);
    idle_cycles(3);
    for (int k = 0; k < 2; k++) begin
      check("par_dout_a", k, 32'(dout_q[k][0]), 32'h00AA);
      check("par_dout_b", k, 32'(dout_q[k][1]), 32'h0055);
    end

    // Same-address double write with per-lane priority.
    step(wr(8'h20, 16'h1234, 2'b01), wr(8'h20, 16'hABCD, 2'b11), 1'b0);
    step(idle(), idle(), 1'b0);
    for (int k = 0; k < 2; k++) begin
      check("dw_coll", k, 32'(coll_q[k]), 32'h1);
      check("dw_cnt", k, cnt_q[k], 32'h1);
    end
    step(rd(8'h20), idle(), 1'b0);
    idle_cycles(3);
    check("dw_word", 0, 32'(dout_q[0][0]), 32'hAB34);
    check("dw_word", 1, 32'(dout_q[1][0]), 32'hABCD);

    // Cross-port read during write.
    step(wr(8'h30, 16'h0011, 2'b11), idle(), 1'b0);
    step(wr(8'h30, 16'h0022, 2'b11), rd(8'h30), 1'b0);
    step(idle(), idle(), 1'b0);
    for (int k = 0; k < 2; k++) check("rdw_cnt", k, cnt_q[k], 32'h2);
    idle_cycles(2);
    check("rdw_dout_b", 0, 32'(dout_q[0][1]), 32'h0011);
    check("rdw_dout_b", 1, 32'(dout_q[1][1]), 32'h0022);

    // Saturation of the narrow counter; the wide one keeps counting.
    for (int j = 0; j < 3; j++) begin
      step(wr(AW'(8'h40 + j), 16'h0101, 2'b10), rd(AW'(8'h40 + j)), 1'b0);
      step(idle(), idle(), 1'b0);
      check("sat_coll", 0, 32'(coll_q[0]), 32'h1);
      check("sat_cnt", 0, cnt_q[0], 32'h3);
      check("sat_cnt", 1, cnt_q[1], 32'(3 + j));
    end

    // Same-address dual read is not a collision.
    step(rd(8'h41), rd(8'h41), 1'b0);
    step(idle(), idle(), 1'b0);
    for (int k = 0; k < 2; k++) check("dual_rd_coll", k, 32'(coll_q[k]), 32'h0);

    // Out-of-range write is dropped and the read returns zero.
    step(wr(8'd250, 16'hFFFF, 2'b11), idle(), 1'b0);
    step(rd(8'd250), idle(), 1'b0);
    idle_cycles(3);
    for (int k = 0; k < 2; k++) check("oor_dout", k, 32'(dout_q[k][0]), 32'h0);

    // Reset after issue kills the pending read of the two-stage instance.
    step(rd(8'h05), idle(), 1'b0);
    step(idle(), idle(), 1'b1);
    step(idle(), idle(), 1'b1);
    step(idle(), idle(), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(idle(), idle(), 1'b0);
      check("abort_rvalid", 0, 32'(rvalid_q[0][0]), 32'h0);
    end

    // Randomised traffic concentrated on a few addresses to force conflicts.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(idle(), idle(), 1'b1);
      end else begin
        ra.cs   = ($urandom_range(0, 3) != 0);
        ra.we   = $urandom_range(0, 1) == 1;
        ra.be   = 2'($urandom);
        ra.addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 15));
        ra.din  = DW'($urandom);
        rb.cs   = ($urandom_range(0, 3) != 0);
        rb.we   = $urandom_range(0, 1) == 1;
        rb.be   = 2'($urandom);
        rb.addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(200, 255)) : AW'($urandom_range(0, 15));
        rb.din  = DW'($urandom);
        step(ra, rb, 1'b0);
      end
    end
    idle_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dp_ram_arb.md
Name: dp_ram_arb

Overview:
Parametrised true dual-port synchronous RAM for the display/register subsystem, replacing the single-write-per-cycle, tri-state shared-bus RAM.
- Two independent ports (A, B) with separate data-in/data-out buses, no tri-states.
- Byte-lane write enables.
- Deterministic same-address write arbitration with a saturating collision counter.
- Selectable cross-port read-during-write behaviour.
- Optional output register stage, with a read-valid flag per port.

Parameters:
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 8: address width.
- RAM_DEPTH, 1<<ADDR_WIDTH: number of words; must be ≤ 2^ADDR_WIDTH.
- PRIO_B, 0: 0 = port A wins same-address write lanes; 1 = port B wins.
- RDW_NEW, 0: cross-port read of an address written the same cycle. 0 = returns old data; 1 = returns newly written data.
- OUT_REG, 0: 1 adds one output pipeline stage (read latency 2 instead of 1).
- CNT_WIDTH, 16: collision counter width.

Ports:
- clk, input, 1: clock; all logic on rising edge.
- reset, input, 1: asynchronous active-high reset.
- cs_a, input, 1: port A select.
- we_a, input, 1: port A write (1) / read (0); ignored when cs_a=0.
- be_a, input, DATA_WIDTH/8: port A byte enables; bit i covers bits [8i+7:8i].
- addr_a, input, ADDR_WIDTH: port A address.
- din_a, input, DATA_WIDTH: port A write data.
- dout_a, output, DATA_WIDTH: port A read data.
- rvalid_a, output, 1: dout_a holds the result of a read.
- cs_b, we_b, be_b, addr_b, din_b, dout_b, rvalid_b: as for port A.
- collision, output, 1: registered pulse marking a same-address access conflict.
- collision_cnt, output, CNT_WIDTH: saturating count of collisions.

Behaviour:
- **Reset:**
  - dout_a, dout_b, rvalid_a, rvalid_b, collision and collision_cnt all go to 0; pipeline registers are cleared.
  - Memory contents are not reset.
  - Reset asserted mid-read kills that read: no rvalid is produced after release.
- **Write:** when cs&we, each enabled byte lane of mem[addr] is updated at the clock edge.
  - Writes to different addresses on both ports complete in the same cycle.
  - A write with be=0 changes nothing but still counts as a write for collision purposes.
- **Same-address double write:** resolved per lane.
  - Lane takes the priority port's byte if the priority port enables that lane.
  - Otherwise it takes the other port's byte if enabled; otherwise the lane is unchanged.
- **Read:** when cs & !we, the word is captured at edge N.
  - OUT_REG=0: dout and rvalid are valid after edge N (latency 1).
  - OUT_REG=1: valid after edge N+1 (latency 2).
  - rvalid is high for exactly one cycle per read; back-to-back reads give one word per cycle.
  - When no read completes, dout holds its last value and rvalid=0.
- **Writing port output:** a port performing a write produces no read data (rvalid stays 0).
- **Cross-port read-during-write (same address):**
  - RDW_NEW=0: the reader gets the pre-write word.
  - RDW_NEW=1: the reader gets the post-arbitration merged word.
- **Out of range:** addresses ≥ RAM_DEPTH drop writes; reads return all zeros with rvalid asserted.
- **Collision:**
  - Condition: cs_a & cs_b & (addr_a==addr_b) & (we_a|we_b).
  - collision is high for one cycle after the conflicting edge.
  - collision_cnt increments by 1 per collision and saturates at 2^CNT_WIDTH−1.
  - Same-address dual reads are not collisions.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package dp_ram_pkg:
  - Constant BYTE_W=8.
  - Function for lane count (DATA_WIDTH/8).
  - Byte-merge function (winner/loser data + enables → merged word).
  - Saturating-increment function.
- Sub-module dp_ram_rd_stage:
  - Read-result register plus optional OUT_REG stage plus rvalid generation.
  - Instantiated once per port.

Test Plan:
- Reset then read: reset=1 for 2 cycles, read A addr 0x10 → dout_a=0, rvalid_a=0 during reset; rvalid_a=1 one cycle after read issue (OUT_REG=0), two cycles after (OUT_REG=1).
- Parallel writes: A writes 0xAA to 0x05 while B writes 0x55 to 0x06, same cycle → reads return 0xAA and 0x55; collision=0.
- Double write, DATA_WIDTH=16, PRIO_B=0: A writes 0x1234 with be=01, B writes 0xABCD with be=11 to 0x20 → mem[0x20]=0xAB34; collision pulses; collision_cnt=1.
- Read-during-write: mem[0x30]=0x11; A writes 0x22 to 0x30 while B reads 0x30 → dout_b=0x11 (RDW_NEW=0) or 0x22 (RDW_NEW=1); cnt increments.
- Saturation: CNT_WIDTH=2, five collisions → collision_cnt 1,2,3,3,3; collision pulses each time.
- Out-of-range and abort: RAM_DEPTH=200, write then read addr 250 → dout=0 with rvalid=1; issue read then assert reset before the data appears → no rvalid after reset release.
